fx_ln_interp_pipe: RTL and testbench
====================================

Name: fx_ln_interp_pipe

Overview:
Next-generation natural-log unit for the fixed-point LSM datapath (basis/discount terms, Box-Muller ln(u)).
- Accepts any positive unsigned fixed-point x, not a restricted sub-range.
- Range-reduces x = m·2^e with m in [1,2), reads two adjacent mantissa-table entries and linearly interpolates.
- Output is ln(x) = interp(m) + e·LN2.
- 4-stage pipeline with valid/ready backpressure on both sides; sits between the uniform-sample source and the normal-generator stages.

Parameters:
- WIDTH, 32: data width of x and ln_out.
- FRAC, 16: fractional bits. x is unsigned Q(WIDTH-FRAC).FRAC; ln_out is signed, same FRAC.
- ADDR_WIDTH, 8: mantissa-table index bits. The table holds 2^ADDR_WIDTH+1 entries.
- INTERP_BITS, 8: mantissa bits used as the interpolation fraction. Requires ADDR_WIDTH+INTERP_BITS <= WIDTH-1; elaboration error otherwise.
- LUT_FILE, "ln_mant_lut_q16.hex": $readmemh init file. Entry i = round(ln(1+i/2^ADDR_WIDTH)·2^FRAC), unsigned, nondecreasing.
- LN2_Q, 45426: round(ln2·2^FRAC) for FRAC=16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  input sample valid
- ready_in  out  1  block can accept; transfer when valid_in && ready_in
- x  in  WIDTH  unsigned fixed-point operand
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts; transfer when valid_out && ready_out
- ln_out  out  WIDTH  signed ln(x), Q.FRAC, saturated
- err_out  out  1  qualifies ln_out: x was 0, or result saturated

Behaviour:
- Reset: synchronous on posedge clk when rst=1. All stage valids clear; valid_out=0, ln_out=0, err_out=0. ready_in=1 in the cycle after reset deasserts. Reset mid-stream discards all in-flight samples and produces no output for them.
- Stall: stall = valid_out && !ready_out.
  - ready_in = !stall.
  - On stall, every stage register holds, including ROM read registers.
  - Bubbles are not compressed. The pipeline advances as a whole.
- Latency: 4 cycles from input transfer to valid_out with no stall. Throughput is 1 sample/cycle.
- S0 (normalize):
  - p = bit position of the leading one of x.
  - e = p - FRAC, signed, clog2(WIDTH)+1 bits.
  - xn = x << (WIDTH-1-p).
  - idx = xn[WIDTH-2 -: ADDR_WIDTH].
  - f = xn[WIDTH-2-ADDR_WIDTH -: INTERP_BITS]. Lower bits are truncated.
  - zero flag = (x==0).
- S1 (table):
  - Registered reads y0 = LUT[idx] and y1 = LUT[idx+1] (two read ports or a dual-port ROM).
  - Computes eln = e·LN2_Q as a signed, WIDTH+clog2(WIDTH) bits wide product.
- S2 (interp):
  - d = y1 - y0 (nonnegative).
  - yi = y0 + ((d·f) >> INTERP_BITS). The shift truncates.
- S3 (combine, output register):
  - s = eln + yi, computed at full width.
  - If s > 2^(WIDTH-1)-1: ln_out = max positive, err_out = 1.
  - If s < -2^(WIDTH-1): ln_out = min negative, err_out = 1.
  - x == 0: ln_out = 2^(WIDTH-1) (most negative), err_out = 1.
  - Otherwise ln_out = s, err_out = 0.
- Boundaries:
  - idx = 2^ADDR_WIDTH-1 reads entry 2^ADDR_WIDTH (= LN2_Q). No wrap-around.
  - x = 1 LSB gives e = -FRAC.
  - x with the top bit set gives e = WIDTH-1-FRAC.
  - Exact powers of two give f = 0 and yi = y0.
- Outputs are stable while valid_out && !ready_out.
- With a stall and valid_in=1 in the same cycle, no input transfer occurs.

Test Plan:
- Reset, then x=0x00010000 (1.0) -> 4 cycles later valid_out=1, ln_out=0x00000000, err_out=0.
- x=0x00008000 (0.5) -> ln_out=0xFFFF4E8E (-45426). x=0x00020000 (2.0) -> ln_out=0x0000B172.
- x=0x00000001 (2^-16) -> ln_out=0xFFF4E8E0 (-726816). x=0 -> ln_out=0x80000000, err_out=1.
- Back-to-back stream of 256 random nonzero x with ready_out toggled randomly (~50%):
  - Outputs appear in order with no drops or duplicates.
  - ln_out and err_out hold while stalled.
  - Each result is within 2 LSB of a bit-accurate model of this algorithm.
  - Each result is within 2^-10 of real ln(x).
- Hold ready_out=0 for 10 cycles with valid_in=1 -> ready_in=0 after valid_out asserts, and exactly 4 samples are buffered. On release, they drain at 1/cycle, then input resumes.
- Assert rst for 1 cycle with 3 samples in flight -> no valid_out for those samples. The next accepted x=0x00010000 yields ln_out=0 after 4 cycles.

Source files
------------

// File: rtl/fx_ln_interp_pipe.sv
// Pipelined fixed-point natural log: leading-one normalization, paired mantissa-table
// reads, linear interpolation and exponent recombination with saturation.
module fx_ln_interp_pipe #(
  parameter int WIDTH       = 32,
  parameter int FRAC        = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int INTERP_BITS = 8,
  parameter     LUT_FILE    = "ln_mant_lut_q16.hex",
  parameter int LN2_Q       = 45426
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] x,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] ln_out,
  output logic             err_out
);

  localparam int LW    = $clog2(WIDTH);
  localparam int EW    = LW + 1;
  localparam int ELW   = WIDTH + LW;
  localparam int SW    = ELW + 1;
  localparam int MW    = ADDR_WIDTH + INTERP_BITS;
  localparam int DEPTH = (1 << ADDR_WIDTH) + 1;
  localparam int PW    = WIDTH + INTERP_BITS;

  localparam logic signed [SW-1:0] MAX_POS = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_NEG = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  if (MW > WIDTH - 1) begin : g_cfg_check
    $error("fx_ln_interp_pipe: ADDR_WIDTH+INTERP_BITS must not exceed WIDTH-1");
  end
  if ($bits(LUT_FILE) < 8) begin : g_lut_name_check
    $error("fx_ln_interp_pipe: LUT_FILE must name the mantissa table image");
  end

  // Table contents are derived at elaboration with the same rounding as the LUT_FILE
  // image: entry i = round(ln(1+i/2^ADDR_WIDTH)*2^FRAC), via ln(1+t) = 2*atanh(t/(2+t)).
  function automatic longint lut_entry(input int i);
    longint z, z2, term, acc;
    z    = (longint'(i) <<< 30) / longint'((2 << ADDR_WIDTH) + i);
    z2   = (z * z) >>> 30;
    term = z;
    acc  = 0;
    for (int k = 1; k < 40; k += 2) begin
      acc  = acc + term / longint'(k);
      term = (term * z2) >>> 30;
    end
    return ((2 * acc) + (64'sd1 <<< (29 - FRAC))) >>> (30 - FRAC);
  endfunction

  logic [WIDTH-1:0] lut [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_lut
    localparam longint ENTRY = lut_entry(g);
    assign lut[g] = WIDTH'(ENTRY);
  end

  logic stall;
  logic advance;

  logic [LW-1:0]          lead_c;
  logic [LW-1:0]          shift_c;
  logic [MW-1:0]          mant_c;
  logic signed [EW-1:0]   e_c;

  logic                   v0;
  logic [ADDR_WIDTH-1:0]  idx0;
  logic [INTERP_BITS-1:0] f0;
  logic signed [EW-1:0]   e0;
  logic                   zero0;

  logic [ADDR_WIDTH:0]    idx_next_c;
  logic                   v1;
  logic [WIDTH-1:0]       y0_1;
  logic [WIDTH-1:0]       y1_1;
  logic [INTERP_BITS-1:0] f1;
  logic signed [ELW-1:0]  eln1;
  logic                   zero1;

  logic [WIDTH-1:0]       d_c;
  logic [PW-1:0]          prod_c;
  logic [WIDTH-1:0]       yi_c;
  logic                   v2;
  logic [WIDTH-1:0]       yi2;
  logic signed [ELW-1:0]  eln2;
  logic                   zero2;

  logic signed [SW-1:0]   s_c;

  // The whole pipeline freezes while the output register holds an unaccepted result.
  assign stall   = valid_out && !ready_out;
  assign advance = !stall;
  assign ready_in = advance;

  always_comb begin
    lead_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) lead_c = LW'(i);
    end
    shift_c = LW'(WIDTH - 1) - lead_c;
    // Drop the leading one; keep the table index and interpolation fraction just below it.
    mant_c  = MW'((x << shift_c) >> (WIDTH - 1 - MW));
    e_c     = EW'({1'b0, lead_c}) - EW'(FRAC);
  end

  always_comb begin
    idx_next_c = {1'b0, idx0} + (ADDR_WIDTH+1)'(1);
    d_c        = y1_1 - y0_1;
    prod_c     = PW'(d_c) * PW'(f1);
    yi_c       = y0_1 + WIDTH'(prod_c >> INTERP_BITS);
    s_c        = SW'(eln2) + SW'(yi2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      ln_out    <= '0;
      err_out   <= 1'b0;
    end else if (advance) begin
      v0    <= valid_in;
      idx0  <= mant_c[MW-1 -: ADDR_WIDTH];
      f0    <= mant_c[INTERP_BITS-1:0];
      e0    <= e_c;
      zero0 <= (x == '0);

      v1    <= v0;
      y0_1  <= lut[{1'b0, idx0}];
      y1_1  <= lut[idx_next_c];
      f1    <= f0;
      eln1  <= ELW'(e0) * ELW'(LN2_Q);
      zero1 <= zero0;

      v2    <= v1;
      yi2   <= yi_c;
      eln2  <= eln1;
      zero2 <= zero1;

      valid_out <= v2;
      if (zero2) begin
        ln_out  <= {1'b1, {(WIDTH-1){1'b0}}};
        err_out <= 1'b1;
      end else if (s_c > MAX_POS) begin
        ln_out  <= {1'b0, {(WIDTH-1){1'b1}}};
        err_out <= 1'b1;
      end else if (s_c < MIN_NEG) begin
        ln_out  <= {1'b1, {(WIDTH-1){1'b0}}};
        err_out <= 1'b1;
      end else begin
        ln_out  <= s_c[WIDTH-1:0];
        err_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fx_ln_interp_pipe.sv
// Directed and streaming checks for fx_ln_interp_pipe against hand values and a
// reference model of the normalize / table / interpolate algorithm.
module tb_fx_ln_interp_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] x;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] ln_out;
  logic        err_out;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint tab [0:256];

  localparam logic [31:0] DX   [8] = '{32'h00010000, 32'h00008000, 32'h00020000, 32'h00000001,
                                       32'h00000000, 32'h80000000, 32'h00018000, 32'h0001FFFF};
  localparam logic [31:0] DEXP [8] = '{32'h00000000, 32'hFFFF4E8E, 32'h0000B172, 32'hFFF4E8E0,
                                       32'h80000000, 32'h000A65AE, 32'h000067CD, 32'h0000B171};
  localparam logic        DERR [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  fx_ln_interp_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .x         (x),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .ln_out    (ln_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_ln(input logic [31:0] xv);
    int     p;
    longint xn, y0, y1, yi, s;
    int     idx, f;
    p = 0;
    for (int i = 0; i < 32; i++) if (xv[i]) p = i;
    xn  = longint'(xv) << (31 - p);
    idx = int'((xn >> 23) & 255);
    f   = int'((xn >> 15) & 255);
    y0  = tab[idx];
    y1  = tab[idx + 1];
    yi  = y0 + (((y1 - y0) * longint'(f)) >>> 8);
    s   = longint'(p - 16) * 45426 + yi;
    return s[31:0];
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] v;
    v = $urandom() >> $urandom_range(0, 31);
    if (v == 0) v = 32'd1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; x = '0; ready_out = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_out got %b want 0", valid_out); end
    n_tests++;
    if (ln_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ln_out got %h want 00000000", ln_out); end
    n_tests++;
    if (err_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err_out got %b want 0", err_out); end
    n_tests++;
    if (ready_in !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready_in got %b want 1", ready_in); end
    tick();
  endtask

  task automatic test_directed();
    int lat;
    for (int v = 0; v < 8; v++) begin
      valid_in = 1'b1; x = DX[v]; ready_out = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ready_in !== 1'b1) begin n_fail++; $display("[TB] FAIL dir%0d_ready_in got %b want 1", v, ready_in); end
      tick();
      valid_in = 1'b0;
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (valid_out === 1'b1) begin lat = k; break; end
      end
      n_tests++;
      if (lat != 4) begin n_fail++; $display("[TB] FAIL dir%0d_latency got %0d want 4", v, lat); end
      n_tests++;
      if (ln_out !== DEXP[v]) begin n_fail++; $display("[TB] FAIL dir%0d_ln x=%h got %h want %h", v, DX[v], ln_out, DEXP[v]); end
      n_tests++;
      if (err_out !== DERR[v]) begin n_fail++; $display("[TB] FAIL dir%0d_err x=%h got %b want %b", v, DX[v], err_out, DERR[v]); end
      tick();
    end
  endtask

  task automatic test_stall_buffering();
    logic [31:0] sx [4] = '{32'h00010000, 32'h00020000, 32'h00008000, 32'h80000000};
    logic [31:0] se [4] = '{32'h00000000, 32'h0000B172, 32'hFFFF4E8E, 32'h000A65AE};
    int acc = 0;
    int lat;
    ready_out = 1'b0;
    for (int c = 0; c < 10; c++) begin
      valid_in = 1'b1;
      x = (acc < 4) ? sx[acc] : 32'h00030000;
      @(negedge clk);
      if (valid_in && ready_in) acc++;
      if (c == 9) begin
        n_tests++;
        if (ready_in !== 1'b0 || valid_out !== 1'b1) begin
          n_fail++; $display("[TB] FAIL stall_ready_in got ready_in=%b valid_out=%b want 0/1", ready_in, valid_out);
        end
      end
      tick();
    end
    n_tests++;
    if (acc != 4) begin n_fail++; $display("[TB] FAIL stall_buffered got %0d want 4", acc); end
    valid_in = 1'b0; ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (valid_out !== 1'b1 || ln_out !== se[k]) begin
        n_fail++; $display("[TB] FAIL drain%0d got valid=%b ln=%h want 1/%h", k, valid_out, ln_out, se[k]);
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      n_fail++; $display("[TB] FAIL drain_end got valid=%b ready_in=%b want 0/1", valid_out, ready_in);
    end
    tick();
    valid_in = 1'b1; x = 32'h00008000;
    tick();
    valid_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin lat = k; break; end
    end
    n_tests++;
    if (lat != 4 || ln_out !== 32'hFFFF4E8E) begin
      n_fail++; $display("[TB] FAIL resume got lat=%0d ln=%h want 4/ffff4e8e", lat, ln_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] cur, xv, exp_m, held_ln;
    logic        held_err, prev_stall, seen;
    int          sent = 0, recv = 0, cyc = 0;
    longint      diff;
    real         ref_ln, rdiff;
    cur = rand_x(); prev_stall = 1'b0; held_ln = '0; held_err = 1'b0;
    while ((sent < 256 || recv < 256) && cyc < 4000) begin
      valid_in = (sent < 256); x = cur; ready_out = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        n_tests++;
        if (valid_out !== 1'b1 || ln_out !== held_ln || err_out !== held_err) begin
          n_fail++; $display("[TB] FAIL hold got %b/%h/%b want 1/%h/%b", valid_out, ln_out, err_out, held_ln, held_err);
        end
      end
      if (valid_out && ready_out) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("[TB] FAIL stream_extra got ln=%h want no output", ln_out);
        end else begin
          xv    = q.pop_front();
          exp_m = model_ln(xv);
          diff  = longint'($signed(ln_out)) - longint'($signed(exp_m));
          if (diff < 0) diff = -diff;
          if (diff > 2 || err_out !== 1'b0) begin
            n_fail++; $display("[TB] FAIL stream_model x=%h got %h/%b want %h/0", xv, ln_out, err_out, exp_m);
          end
          ref_ln = $ln(real'(xv) / 65536.0) * 65536.0;
          rdiff  = real'(longint'($signed(ln_out))) - ref_ln;
          if (rdiff < 0.0) rdiff = -rdiff;
          n_tests++;
          if (rdiff > 64.0) begin
            n_fail++; $display("[TB] FAIL stream_real x=%h got %h want %f", xv, ln_out, ref_ln);
          end
          recv++;
        end
      end
      if (valid_in && ready_in) begin
        q.push_back(cur); sent++; cur = rand_x();
      end
      prev_stall = valid_out && !ready_out;
      held_ln = ln_out; held_err = err_out;
      tick();
      cyc++;
    end
    n_tests++;
    if (sent != 256 || recv != 256) begin
      n_fail++; $display("[TB] FAIL stream_count got sent=%0d recv=%0d want 256/256", sent, recv);
    end
    valid_in = 1'b0; ready_out = 1'b1; seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | valid_out;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_dup got valid_out=1 want 0"); end
  endtask

  task automatic test_reset_midstream();
    logic seen = 1'b0;
    int   lat;
    ready_out = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1; x = 32'h00020000 + 32'(k);
      tick();
    end
    valid_in = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | valid_out;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL flush got valid_out=1 want 0"); end
    valid_in = 1'b1; x = 32'h00010000;
    tick();
    valid_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin lat = k; break; end
    end
    n_tests++;
    if (lat != 4 || ln_out !== 32'h0 || err_out !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_reset got lat=%0d ln=%h err=%b want 4/00000000/0", lat, ln_out, err_out);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; x = '0; ready_out = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      tab[i] = longint'($floor($ln(1.0 + real'(i) / 256.0) * 65536.0 + 0.5));
    end
    test_reset();
    test_directed();
    test_stall_buffering();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
